seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_div_pkg.sv | 12 +
 rtl/div_step.sv | 38 +++
 rtl/seq_divider.sv | 115 +++++++++++
 tb/tb_seq_divider.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// The partial remainder takes in the MSB of the quotient shift register.
// A trial subtract then decides the next quotient bit, which shifts into
// the LSB of the same register.
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // One extra bit holds the sign of the trial subtract. The partial
  // remainder is always below the divisor, so the difference cannot wrap.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign fits    = ~trial[WIDTH];

  // Keep the difference when it is non-negative; otherwise restore.
  assign rem_out = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  // Shift the quotient register left by one bit; the new quotient bit enters at the LSB.
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_qshift
      assign quo_out[gi] = quo_in[gi-1];
    end
  endgenerate
  assign quo_out[0] = fits;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle.
// A zero divisor skips CALC and reports all-ones / dividend with a flag.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             zero_flag
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, quo_reg, div_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic [CW-1:0]    cnt_reg;
  logic             dbz_reg;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] step_rem, step_quo;

  // A new operation may only begin outside CALC.
  assign accept    = start && (state_reg != CALC);
  assign last_step = (state_reg == CALC) && (cnt_reg <= CNT_LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (div_reg),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic. A zero divisor goes straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (accept) state_next = (divisor == '0) ? DONE : CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_reg == CALC);
    done = (state_reg == DONE);
  end

  // Datapath: latch operands, iterate, and publish results on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg       <= '0;
      quo_reg       <= '0;
      div_reg       <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      div_reg <= divisor;
      rem_reg <= '0;
      quo_reg <= dividend;
      dbz_reg <= 1'b0;
      if (divisor == '0) begin
        cnt_reg       <= '0;
        quotient_reg  <= '1;
        remainder_reg <= dividend;
        dbz_reg       <= 1'b1;
      end else begin
        cnt_reg <= CNT_LOAD;
      end
    end else if (state_reg == CALC) begin
      rem_reg <= step_rem;
      quo_reg <= step_quo;
      cnt_reg <= cnt_reg - CNT_LAST;
      if (last_step) begin
        quotient_reg  <= step_quo;
        remainder_reg <= step_rem;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign zero_flag   = (quotient_reg == '0);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider.
// Stimulus pushes reference results; an independent monitor pops and
// compares them on every done pulse.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, zero_flag;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .zero_flag   (zero_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           a;
    int           b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         zf;
    int           at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all ones / dividend.
  function automatic exp_t ref_div(input int a, input int b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.dbz = (b == 0);
    e.q   = (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    e.r   = (b == 0) ? W'(a) : W'(a % b);
    e.zf  = (e.q == '0);
    e.at  = 0;
    return e;
  endfunction

  // Drive one start pulse. With sync=0 the pulse starts at the current negedge.
  task automatic issue(input int a, input int b, input bit sync);
    exp_t e;
    if (sync) @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    e = ref_div(a, b);
    e.at = cyc + 1 + ((b == 0) ? 0 : W);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    chk("wait_done", done, 1);
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("busy_with_done", busy, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.dbz);
        chk("zero_flag", zero_flag, mon_e.zf);
        chk("latency", cyc, mon_e.at);
        $display("DONE %0d / %0d -> q=%0d r=%0d dbz=%0d zf=%0d at cycle %0d",
                 mon_e.a, mon_e.b, quotient, remainder, div_by_zero, zero_flag, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    chk("reset_zero_flag", zero_flag, 1);
    rst_n = 1'b1;

    // Directed cases.
    issue(8, 2, 1);
    wait_drain();

    issue(15, 0, 1);
    repeat (3) begin
      chk("dbz_busy", busy, 0);
      @(negedge clk);
    end
    wait_drain();

    issue(7, 9, 1);   wait_drain();
    issue(15, 1, 1);  wait_drain();
    issue(13, 4, 1);  wait_drain();

    // Start while busy is ignored.
    issue(9, 3, 1);
    @(negedge clk);
    chk("busy_in_calc", busy, 1);
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);

    // Back-to-back start in the DONE cycle.
    issue(11, 3, 1);
    wait_done();
    issue(12, 5, 0);
    wait_drain();

    // Reset in the middle of CALC aborts the operation.
    issue(11, 2, 1);
    @(negedge clk);
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_zero_flag", zero_flag, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    repeat (W + 3) @(negedge clk);
    issue(6, 3, 1);
    wait_drain();

    // Randomized operations, some chained back-to-back.
    for (int n = 0; n < 60; n++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
      issue(a, b, 1);
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        a = int'($urandom_range(0, (1 << W) - 1));
        b = int'($urandom_range(0, (1 << W) - 1));
        issue(a, b, 0);
      end
      wait_drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("final_queue", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
